hilo_mult_unit: RTL and testbench

- Sequential multiply/HI-LO register stage for the 32-bit datapath.
- Consumes the combinational products of the existing MULT32 (signed) and MULT32_U (unsigned) multipliers over a multicycle path.
- Commits the 64-bit result to architectural HI/LO registers.
- Serves MFHI/MFLO reads with a stall while a multiply is in flight.
- Also executes MTHI/MTLO writes.

---
 rtl/hilo_mult_unit_pkg.sv | 13 +
 rtl/hilo_mult_unit_if.sv | 29 ++
 rtl/hilo_mult_unit_mult32.sv | 18 +
 rtl/hilo_mult_unit.sv | 70 +++++++
 tb/tb_hilo_mult_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/hilo_mult_unit_pkg.sv
// hilo_mult_unit_pkg: shared op and FSM state encodings for the HI/LO multiply stage
package hilo_mult_unit_pkg;
    localparam logic [1:0] HILO_OP_MULT  = 2'b00;
    localparam logic [1:0] HILO_OP_MULTU = 2'b01;
    localparam logic [1:0] HILO_OP_MTHI  = 2'b10;
    localparam logic [1:0] HILO_OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;
endpackage

// File: rtl/hilo_mult_unit_if.sv
// hilo_mult_unit_if: request, status, HI/LO and read-port bundle for hilo_mult_unit
//   start/op/a/b  : operation request from the issuer
//   busy/done     : multiply in flight / one-cycle commit pulse
//   hi/lo         : architectural registers
//   rd_req/rd_sel : MFHI/MFLO request, rd_data/stall its answer
interface hilo_mult_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        stall;

    modport master (
        output start, op, a, b, rd_req, rd_sel,
        input  busy, done, hi, lo, rd_data, stall
    );

    modport slave (
        input  start, op, a, b, rd_req, rd_sel,
        output busy, done, hi, lo, rd_data, stall
    );
endinterface

// File: rtl/hilo_mult_unit_mult32.sv
// mult32 / mult32_u: combinational 32x32->64 signed and unsigned multipliers
//   a, b : operands
//   p    : full 64-bit product
module mult32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
endmodule

module mult32_u (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = {32'b0, a} * {32'b0, b};
endmodule

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: multicycle multiply stage committing 64-bit products to HI/LO, plus MTHI/MTLO and stalled reads
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of hilo_mult_unit_if
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 3
) (
    input logic clk,
    input logic rst,
    hilo_mult_unit_if.slave bus
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic sgn_q, done_q, issue, is_mul;
    logic [63:0] prod_s, prod_u, prod;

    // The multipliers see only the latched operands, so the bus may change during WAIT.
    mult32 u_mult32 (.a(a_q), .b(b_q), .p(prod_s));
    mult32_u u_mult32_u (.a(a_q), .b(b_q), .p(prod_u));

    assign prod   = sgn_q ? prod_s : prod_u;
    assign issue  = state == ST_IDLE && bus.start;
    assign is_mul = bus.op == HILO_OP_MULT || bus.op == HILO_OP_MULTU;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = state == ST_IDLE ? (issue && is_mul ? ST_WAIT : ST_IDLE)
                 : state == ST_WAIT ? (cnt == '0 ? ST_COMMIT : ST_WAIT)
                 : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= state == ST_COMMIT;
            if (issue && is_mul) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                sgn_q <= bus.op == HILO_OP_MULT;
                cnt   <= CNT_W'(LATENCY - 1);
            end
            if (state == ST_WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (issue && bus.op == HILO_OP_MTHI) hi_q <= bus.a;
            if (issue && bus.op == HILO_OP_MTLO) lo_q <= bus.a;
            if (state == ST_COMMIT) {hi_q, lo_q} <= prod;
        end
    end

    assign bus.busy    = state != ST_IDLE;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
    assign bus.stall   = bus.rd_req && state != ST_IDLE;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: table-driven, directed and random checks of hilo_mult_unit against an arithmetic model
module tb_hilo_mult_unit;
    import hilo_mult_unit_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    vec_t tbl[9];

    hilo_mult_unit_if bus ();

    hilo_mult_unit #(.LATENCY(LAT), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int ia, ib;
        longint unsigned ua, ub;
        ia = a;
        ib = b;
        ua = a;
        ub = b;
        return op == HILO_OP_MULT ? 64'(longint'(ia) * longint'(ib)) : 64'(ua * ub);
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        int cyc, bcnt;
        issue(op, a, b);
        if (op[1]) begin
            check({name, " mt busy"}, bus.busy, 0);
            check({name, " mt done"}, bus.done, 0);
        end else begin
            cyc = 0;
            bcnt = 0;
            while (!bus.done && cyc < 20) begin
                if (bus.busy) bcnt++;
                @(posedge clk); #1;
                cyc++;
            end
            check({name, " done latency"}, cyc, LAT + 1);
            check({name, " busy cycles"}, bcnt, LAT + 1);
            check({name, " busy in done"}, bus.busy, 0);
        end
        check({name, " hi"}, bus.hi, hi);
        check({name, " lo"}, bus.lo, lo);
        model_hi = hi;
        model_lo = lo;
    endtask

    initial begin
        int cyc, stalls;
        logic seen;
        logic [1:0] op;
        logic [31:0] a, b;
        logic [63:0] p;
        logic [31:0] pool[4];
        pool = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

        tbl[0] = '{HILO_OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[1] = '{HILO_OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        tbl[2] = '{HILO_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[3] = '{HILO_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[4] = '{HILO_OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        tbl[5] = '{HILO_OP_MULT,  32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000};
        tbl[6] = '{HILO_OP_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'h00000000};
        tbl[7] = '{HILO_OP_MTLO,  32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0};
        tbl[8] = '{HILO_OP_MULT,  32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};

        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.rd_req = 1'b1;
        bus.rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset stall", bus.stall, 0);
        bus.rd_req = 1'b0;

        issue(HILO_OP_MULT, 32'h5, 32'h7);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            if (bus.done || bus.busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort no done/busy", seen, 0);
        check("abort hi", bus.hi, 0);
        check("abort lo", bus.lo, 0);
        run_op("after abort", HILO_OP_MULT, 32'h5, 32'h7, 32'h0, 32'h23);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
            @(posedge clk); #1;
            check($sformatf("vec%0d done one cycle", i), bus.done, 0);
        end

        bus.start = 1'b1;
        bus.op = HILO_OP_MTHI;
        bus.a = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("mt pair busy 1", bus.busy, 0);
        bus.op = HILO_OP_MTLO;
        bus.a = 32'h0BADBEEF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("mt pair busy 2", bus.busy, 0);
        check("mt pair done", bus.done, 0);
        check("mt pair hi", bus.hi, 32'hCAFEF00D);
        check("mt pair lo", bus.lo, 32'h0BADBEEF);

        bus.rd_req = 1'b1;
        bus.rd_sel = 1'b1;
        issue(HILO_OP_MULT, 32'h00010000, 32'h00010000);
        cyc = 0;
        stalls = 0;
        while (!bus.done && cyc < 20) begin
            if (bus.stall) stalls++;
            if (cyc == 1) begin
                bus.start = 1'b1;
                bus.op = HILO_OP_MTLO;
                bus.a = 32'hDEADBEEF;
            end else if (cyc == 2) begin
                bus.start = 1'b0;
                bus.a = 32'h7;
                bus.b = 32'h9;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("stall cycles", stalls, LAT + 1);
        check("stall in done", bus.stall, 0);
        check("read hi in done", bus.rd_data, 32'h1);
        check("ignored mtlo lo", bus.lo, 32'h0);
        bus.rd_sel = 1'b0;
        #1;
        check("read lo", bus.rd_data, 32'h0);
        bus.rd_req = 1'b0;
        model_hi = 32'h1;
        model_lo = 32'h0;
        @(posedge clk); #1;

        run_op("b2b first", HILO_OP_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        check("b2b in done cycle", bus.done, 1);
        run_op("b2b second", HILO_OP_MULT, 32'h3, 32'h5, 32'h0, 32'hF);

        repeat (60) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom_range(0, 3) == 0 ? pool[$urandom_range(0, 3)] : $urandom;
            b = $urandom_range(0, 3) == 0 ? pool[$urandom_range(0, 3)] : $urandom;
            p = ref_prod(op, a, b);
            if (op == HILO_OP_MTHI) p = {a, model_lo};
            if (op == HILO_OP_MTLO) p = {model_hi, a};
            run_op($sformatf("rand op%0d %h*%h", op, a, b), op, a, b, p[63:32], p[31:0]);
            bus.rd_sel = 1'($urandom_range(0, 1));
            #1;
            check("rand read", bus.rd_data, bus.rd_sel ? model_hi : model_lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
